// File: rtl/amber_wb_timer_slave.sv
// Wishbone B3 classic register slave: timer0/timer1 counters, UART char and test-out registers.
// Latency: ack/err one cycle after a sampled request; read data registered alongside ack.
// Backpressure: none; each access takes two cycles because ack/err masks the next request.
module amber_wb_timer_slave #(
  parameter logic [31:0] BASE_ADR = 32'h2000_0000,
  parameter int          TIMER_W  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_irq,
  output logic [31:0] timer0_count,
  output logic [31:0] timer1_count,
  output logic [31:0] timer1_match,
  output logic [31:0] timer_control,
  output logic [31:0] timer_status,
  output logic [7:0]  uart_char,
  output logic        uart_char_strobe,
  output logic [31:0] test_out,
  output logic        test_out_strobe
);

  localparam logic [7:0] OFF_T0    = 8'h00;
  localparam logic [7:0] OFF_T1    = 8'h04;
  localparam logic [7:0] OFF_MATCH = 8'h08;
  localparam logic [7:0] OFF_CTRL  = 8'h0C;
  localparam logic [7:0] OFF_STAT  = 8'h10;
  localparam logic [7:0] OFF_UART  = 8'h14;
  localparam logic [7:0] OFF_TEST  = 8'h18;

  logic [TIMER_W-1:0] t0;
  logic [TIMER_W-1:0] t1;
  logic               stat0;
  logic               req;
  logic               hit;
  logic               adr_ok;
  logic               wr;
  logic               rd;
  logic [7:0]         off;
  logic [31:0]        rd_val;
  logic               wr_t1;
  logic               t1_hit;
  logic               stat_clr;

  // Byte-lane merge of write data over the current register value.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  // A new request is only taken when no termination is being driven this cycle.
  assign req = i_wb_cyc & i_wb_stb & ~(o_wb_ack | o_wb_err);
  assign off = i_wb_adr[7:0];

  // Offset decode and read mux, sampling register values before this edge's updates.
  always_comb begin
    hit    = 1'b0;
    rd_val = 32'h0;
    case (off)
      OFF_T0:    begin hit = 1'b1; rd_val = 32'(t0); end
      OFF_T1:    begin hit = 1'b1; rd_val = 32'(t1); end
      OFF_MATCH: begin hit = 1'b1; rd_val = timer1_match; end
      OFF_CTRL:  begin hit = 1'b1; rd_val = timer_control; end
      OFF_STAT:  begin hit = 1'b1; rd_val = {31'h0, stat0}; end
      OFF_UART:  begin hit = 1'b1; rd_val = 32'h0; end
      OFF_TEST:  begin hit = 1'b1; rd_val = test_out; end
      default:   begin hit = 1'b0; rd_val = 32'h0; end
    endcase
  end

  assign adr_ok   = (i_wb_adr[31:8] == BASE_ADR[31:8]) && (i_wb_adr[1:0] == 2'b00) && hit;
  assign wr       = req & adr_ok & i_wb_we;
  assign rd       = req & adr_ok & ~i_wb_we;
  assign wr_t1    = wr && (off == OFF_T1);
  assign stat_clr = wr && (off == OFF_STAT) && i_wb_sel[0] && i_wb_dat[0];
  // A bus write to T1_COUNT pre-empts the match reload, so no status set that cycle.
  assign t1_hit   = timer_control[1] && !wr_t1 && (32'(t1) == timer1_match);

  // Bus termination: ack for decoded accesses, err otherwise; read data only alongside ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'h0;
    end else begin
      o_wb_ack <= req & adr_ok;
      o_wb_err <= req & ~adr_ok;
      o_wb_dat <= rd ? rd_val : 32'h0;
    end
  end

  // Free-running timer0, wraps naturally at 2^TIMER_W.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      t0 <= '0;
    end else if (timer_control[0]) begin
      t0 <= t0 + TIMER_W'(1);
    end
  end

  // timer1 match counter and sticky status; a match set beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      t1    <= '0;
      stat0 <= 1'b0;
    end else begin
      if (wr_t1) begin
        t1 <= TIMER_W'(merge(32'(t1), i_wb_dat, i_wb_sel));
      end else if (timer_control[1]) begin
        t1 <= t1_hit ? '0 : t1 + TIMER_W'(1);
      end
      if (t1_hit) begin
        stat0 <= 1'b1;
      end else if (stat_clr) begin
        stat0 <= 1'b0;
      end
    end
  end

  // Configuration / output registers and their one-cycle write strobes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer1_match     <= 32'h0;
      timer_control    <= 32'h0;
      test_out         <= 32'h0;
      uart_char        <= 8'h0;
      uart_char_strobe <= 1'b0;
      test_out_strobe  <= 1'b0;
    end else begin
      uart_char_strobe <= 1'b0;
      test_out_strobe  <= 1'b0;
      if (wr) begin
        case (off)
          OFF_MATCH: timer1_match  <= merge(timer1_match, i_wb_dat, i_wb_sel);
          OFF_CTRL:  timer_control <= merge(timer_control, i_wb_dat, i_wb_sel);
          OFF_TEST: begin
            test_out        <= merge(test_out, i_wb_dat, i_wb_sel);
            test_out_strobe <= 1'b1;
          end
          OFF_UART: begin
            if (i_wb_sel[0]) begin
              uart_char        <= i_wb_dat[7:0];
              uart_char_strobe <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign timer0_count = 32'(t0);
  assign timer1_count = 32'(t1);
  assign timer_status = {31'h0, stat0};
  assign o_irq        = stat0 & timer_control[2];

endmodule

// File: tb/tb_amber_wb_timer_slave.sv
module tb_amber_wb_timer_slave;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        we = 1'b0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] rdat;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack, err, irq;
  logic [31:0] t0c, t1c, t1m, tctl, tstat, tout;
  logic [7:0]  uchar;
  logic        ustb, tstb;

  int checks = 0;
  int passes = 0;

  // Samples captured by the bus task: cycle after request, and the cycle after that.
  logic        s_ack1, s_err1, s_ack2, s_err2, s_us1, s_us2, s_ts1;
  logic [31:0] s_dat1, s_dat2;

  always #5 clk = ~clk;

  amber_wb_timer_slave dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
    .i_wb_dat(wdat), .o_wb_dat(rdat), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_ack(ack), .o_wb_err(err), .o_irq(irq),
    .timer0_count(t0c), .timer1_count(t1c), .timer1_match(t1m),
    .timer_control(tctl), .timer_status(tstat), .uart_char(uchar),
    .uart_char_strobe(ustb), .test_out(tout), .test_out_strobe(tstb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One access, called just after a rising edge. stb is held through the ack cycle
  // so the following sample also shows that ack drops even with stb still high.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    s_ack1 = ack; s_err1 = err; s_dat1 = rdat; s_us1 = ustb; s_ts1 = tstb;
    @(posedge clk); #1;
    s_ack2 = ack; s_err2 = err; s_dat2 = rdat; s_us2 = ustb;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0;
  endtask

  initial begin
    // Reset held with a live strobe: nothing may respond.
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; adr = BASE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_t0", t0c, 0);
    check("rst_t1", t1c, 0);
    check("rst_dat", rdat, 0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // timer0 enable, then read after 10 cycles.
    bus(1'b1, BASE + 32'h0C, 4'hF, 32'h1);
    check("ctl_ack", 32'(s_ack1), 1);
    check("ctl_noack2", 32'(s_ack2), 0);
    check("t0_first", t0c, 1);
    repeat (10) @(posedge clk);
    #1;
    bus(1'b0, BASE + 32'h00, 4'hF, 32'h0);
    check("t0rd_ack", 32'(s_ack1), 1);
    check("t0rd_range", 32'(s_dat1 >= 10 && s_dat1 <= 13), 1);
    check("t0rd_noack2", 32'(s_ack2), 0);
    check("t0rd_dat0", s_dat2, 0);

    // timer1 match cycle with interrupt.
    bus(1'b1, BASE + 32'h08, 4'hF, 32'h5);
    check("match5", t1m, 5);
    bus(1'b1, BASE + 32'h0C, 4'hF, 32'h6);
    check("t1_1", t1c, 1);
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk); #1;
      check("t1_cnt", t1c, 32'(i));
      check("t1_noirq", 32'(irq), 0);
    end
    @(posedge clk); #1;
    check("t1_wrap", t1c, 0);
    check("stat_set", tstat, 1);
    check("irq_set", 32'(irq), 1);
    bus(1'b0, BASE + 32'h10, 4'hF, 32'h0);
    check("stat_rd", s_dat1, 1);
    bus(1'b1, BASE + 32'h10, 4'hF, 32'h1);
    check("stat_clr", tstat, 0);
    check("irq_clr", 32'(irq), 0);
    bus(1'b1, BASE + 32'h0C, 4'hF, 32'h0);

    // UART char writes.
    bus(1'b1, BASE + 32'h14, 4'b0001, 32'h41);
    check("uart_char", 32'(uchar), 32'h41);
    check("uart_stb1", 32'(s_us1), 1);
    check("uart_stb2", 32'(s_us2), 0);
    bus(1'b1, BASE + 32'h14, 4'b0010, 32'h5555);
    check("uart_nostb", 32'(s_us1), 0);
    check("uart_keep", 32'(uchar), 32'h41);
    bus(1'b0, BASE + 32'h14, 4'hF, 32'h0);
    check("uart_rd0", s_dat1, 0);
    check("uart_rdack", 32'(s_ack1), 1);

    // Error terminations with no side effects.
    bus(1'b0, BASE + 32'h1C, 4'hF, 32'h0);
    check("e1c_err", 32'(s_err1), 1);
    check("e1c_ack", 32'(s_ack1), 0);
    check("e1c_dat", s_dat1, 0);
    check("e1c_err2", 32'(s_err2), 0);
    bus(1'b0, BASE + 32'h101, 4'hF, 32'h0);
    check("e101_err", 32'(s_err1), 1);
    check("e101_ack", 32'(s_ack1), 0);
    bus(1'b1, BASE + 32'h0D, 4'hF, 32'hFF);
    check("emis_err", 32'(s_err1), 1);
    check("emis_ctl", tctl, 0);
    bus(1'b1, 32'h3000_000C, 4'hF, 32'hFF);
    check("ebase_err", 32'(s_err1), 1);
    check("ebase_ctl", tctl, 0);

    // Byte-lane writes.
    bus(1'b1, BASE + 32'h08, 4'hF, 32'h0);
    bus(1'b1, BASE + 32'h08, 4'b0101, 32'hAABBCCDD);
    check("match_sel", t1m, 32'h00BB00DD);
    bus(1'b0, BASE + 32'h08, 4'hF, 32'h0);
    check("match_rd", s_dat1, 32'h00BB00DD);
    bus(1'b1, BASE + 32'h18, 4'b1000, 32'h12345678);
    check("test_out", tout, 32'h12000000);
    check("test_stb", 32'(s_ts1), 1);
    check("test_stb2", 32'(tstb), 0);
    bus(1'b0, BASE + 32'h18, 4'hF, 32'h0);
    check("test_rd", s_dat1, 32'h12000000);
    bus(1'b1, BASE + 32'h04, 4'hF, 32'h100);
    bus(1'b0, BASE + 32'h04, 4'hF, 32'h0);
    check("t1_wrrd", s_dat1, 32'h100);
    check("ack_err_excl", 32'(s_ack1 & s_err1), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
